// File: rtl/sb_pkg.sv
// Shared constants, state types and helpers for the sideband receive path.
package sb_pkg;

   localparam logic [7:0] DLE = 8'hFE;
   localparam logic [7:0] STX = 8'h05;
   localparam logic [7:0] ETX = 8'h40;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } bit_state_t;

   typedef enum logic [1:0] {
      HUNT      = 2'd0,
      HUNT_DLE  = 2'd1,
      IN_FRAME  = 2'd2,
      FRAME_DLE = 2'd3
   } frame_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/sideband_uart_rx.sv
// Sideband bit receiver: synchronizer, optional majority glitch filter
// (SB_RX_GLITCH_FILTER_EN) and start/data/stop bit FSM.
module sideband_uart_rx
   import sb_pkg::*;
#(
   parameter int OVERSAMPLE = 16
)
(
   input  logic       SB_clock,
   input  logic       reset_n,
   input  logic       sbrx,
   input  logic       enable,
   output logic [7:0] rx_byte,
   output logic       byte_done,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          rx_in_s;
   logic          prev_r;
   bit_state_t    state_r;
   logic [CW-1:0] cnt_r;
   logic [2:0]    bit_cnt_r;
   logic [7:0]    shift_r;

   // Two-flop synchronizer; idles high so reset never fakes a start edge
   always_ff @(posedge SB_clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= sbrx;
         sync2_r <= sync1_r;
      end
   end

`ifdef SB_RX_GLITCH_FILTER_EN
   logic hist1_r;
   logic hist2_r;
   logic filt_r;

   // Majority vote over three synchronized samples drops single-cycle glitches
   always_ff @(posedge SB_clock or negedge reset_n) begin
      if (!reset_n) begin
         hist1_r <= 1'b1;
         hist2_r <= 1'b1;
         filt_r  <= 1'b1;
      end else begin
         hist1_r <= sync2_r;
         hist2_r <= hist1_r;
         filt_r  <= maj3(sync2_r, hist1_r, hist2_r);
      end
   end

   assign rx_in_s = filt_r;
`else
   assign rx_in_s = sync2_r;
`endif

   // Bit FSM: centre-sampling of start, eight data bits LSB first, and stop
   always_ff @(posedge SB_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'h00;
         prev_r    <= 1'b1;
         byte_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         prev_r    <= rx_in_s;
         byte_done <= 1'b0;
         frame_err <= 1'b0;
         cnt_r     <= cnt_r + 1'b1;
         if (!enable) begin
            state_r <= IDLE;
            cnt_r   <= '0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (prev_r && !rx_in_s) begin
                     state_r   <= START;
                     cnt_r     <= '0;
                     bit_cnt_r <= 3'd0;
                  end
               end
               START: begin
                  if (cnt_r == HALF_M1) begin
                     cnt_r   <= '0;
                     state_r <= rx_in_s ? IDLE : DATA;
                  end
               end
               DATA: begin
                  if (cnt_r == FULL_M1) begin
                     cnt_r     <= '0;
                     shift_r   <= {rx_in_s, shift_r[7:1]};
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                     if (bit_cnt_r == 3'd7) begin
                        state_r <= STOP;
                     end
                  end
               end
               STOP: begin
                  if (cnt_r == FULL_M1) begin
                     cnt_r <= '0;
                     if (rx_in_s) begin
                        byte_done <= 1'b1;
                        state_r   <= IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state_r   <= BREAK;
                     end
                  end
               end
               BREAK: begin
                  if (rx_in_s) begin
                     state_r <= IDLE;
                  end
               end
               default: state_r <= IDLE;
            endcase
         end
      end
   end

   assign rx_byte = shift_r;
   assign busy    = (state_r != IDLE);

endmodule

// File: rtl/sideband_rx.sv
// Sideband receiver top: DLE STX/ETX frame extraction, unstuffing and a one-byte
// hold register feeding sop/eop-marked payload. Filter option: SB_RX_GLITCH_FILTER_EN.
module sideband_rx
   import sb_pkg::*;
#(
   parameter int OVERSAMPLE  = 16,
   parameter int MAX_PAYLOAD = 64
)
(
   input  logic       SB_clock,
   input  logic       reset_n,
   input  logic       sbrx,
   input  logic       enable,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_sop,
   output logic       rx_eop,
   output logic       frame_err,
   output logic       proto_err,
   output logic       busy
);

   localparam int CNTW = $clog2(MAX_PAYLOAD + 1);
   localparam logic [CNTW-1:0] COUNT_MAX = CNTW'(MAX_PAYLOAD);

   logic [7:0]     uart_byte_s;
   logic           uart_done_s;
   logic           uart_ferr_s;
   logic           uart_busy_s;
   logic           take_s;
   frame_state_t   fstate_r;
   logic [7:0]     hold_r;
   logic           hold_valid_r;
   logic           hold_first_r;
   logic [CNTW-1:0] count_r;

   sideband_uart_rx #(.OVERSAMPLE(OVERSAMPLE)) u_uart (
      .SB_clock (SB_clock),
      .reset_n  (reset_n),
      .sbrx     (sbrx),
      .enable   (enable),
      .rx_byte  (uart_byte_s),
      .byte_done(uart_done_s),
      .frame_err(uart_ferr_s),
      .busy     (uart_busy_s)
   );

   // A payload byte is either a plain byte in frame or the second DLE of a stuffed pair
   always_comb begin
      take_s = 1'b0;
      if (uart_done_s) begin
         if (fstate_r == IN_FRAME) begin
            take_s = (uart_byte_s != DLE);
         end else if (fstate_r == FRAME_DLE) begin
            take_s = (uart_byte_s == DLE);
         end else begin
            take_s = 1'b0;
         end
      end else begin
         take_s = 1'b0;
      end
   end

   // Frame FSM with hold register; the held byte is only released once its successor or ETX is known
   always_ff @(posedge SB_clock or negedge reset_n) begin
      if (!reset_n) begin
         fstate_r     <= HUNT;
         hold_r       <= 8'h00;
         hold_valid_r <= 1'b0;
         hold_first_r <= 1'b0;
         count_r      <= '0;
         rx_data      <= 8'h00;
         rx_valid     <= 1'b0;
         rx_sop       <= 1'b0;
         rx_eop       <= 1'b0;
         proto_err    <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         rx_sop    <= 1'b0;
         rx_eop    <= 1'b0;
         proto_err <= 1'b0;
         if (!enable) begin
            fstate_r     <= HUNT;
            hold_valid_r <= 1'b0;
            count_r      <= '0;
         end else if (uart_ferr_s) begin
            fstate_r     <= HUNT;
            hold_valid_r <= 1'b0;
         end else if (take_s) begin
            if (count_r >= COUNT_MAX) begin
               proto_err    <= 1'b1;
               hold_valid_r <= 1'b0;
               fstate_r     <= HUNT;
            end else begin
               if (hold_valid_r) begin
                  rx_valid <= 1'b1;
                  rx_data  <= hold_r;
                  rx_sop   <= hold_first_r;
               end
               hold_r       <= uart_byte_s;
               hold_valid_r <= 1'b1;
               hold_first_r <= (count_r == '0);
               count_r      <= count_r + 1'b1;
               fstate_r     <= IN_FRAME;
            end
         end else if (uart_done_s) begin
            case (fstate_r)
               HUNT: begin
                  if (uart_byte_s == DLE) begin
                     fstate_r <= HUNT_DLE;
                  end
               end
               HUNT_DLE: begin
                  if (uart_byte_s == STX) begin
                     fstate_r     <= IN_FRAME;
                     count_r      <= '0;
                     hold_valid_r <= 1'b0;
                  end else if (uart_byte_s != DLE) begin
                     fstate_r <= HUNT;
                  end
               end
               IN_FRAME: fstate_r <= FRAME_DLE;
               FRAME_DLE: begin
                  hold_valid_r <= 1'b0;
                  if (uart_byte_s == ETX) begin
                     fstate_r <= HUNT;
                     if (hold_valid_r) begin
                        rx_valid <= 1'b1;
                        rx_data  <= hold_r;
                        rx_sop   <= hold_first_r;
                        rx_eop   <= 1'b1;
                     end else begin
                        proto_err <= 1'b1;
                     end
                  end else if (uart_byte_s == STX) begin
                     proto_err <= 1'b1;
                     fstate_r  <= IN_FRAME;
                     count_r   <= '0;
                  end else begin
                     proto_err <= 1'b1;
                     fstate_r  <= HUNT;
                  end
               end
               default: fstate_r <= HUNT;
            endcase
         end
      end
   end

   assign frame_err = uart_ferr_s;
   assign busy      = uart_busy_s || (fstate_r == IN_FRAME) || (fstate_r == FRAME_DLE);

endmodule

// File: tb/tb_sideband_rx.sv
// Self-checking bench for sideband_rx: directed frames plus random transactions
// checked against a payload-level expectation model.
module tb_sideband_rx;

   localparam int OS   = 16;
   localparam int MAXP = 4;
`ifdef SB_RX_GLITCH_FILTER_EN
   localparam int LAT = 158;
`else
   localparam int LAT = 156;
`endif
   localparam logic [7:0] DLE = 8'hFE;
   localparam logic [7:0] STX = 8'h05;
   localparam logic [7:0] ETX = 8'h40;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sbrx;
   logic       enable;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_sop;
   logic       rx_eop;
   logic       frame_err;
   logic       proto_err;
   logic       busy;

   sideband_rx #(.OVERSAMPLE(OS), .MAX_PAYLOAD(MAXP)) dut (
      .SB_clock (clk),
      .reset_n  (reset_n),
      .sbrx     (sbrx),
      .enable   (enable),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_sop   (rx_sop),
      .rx_eop   (rx_eop),
      .frame_err(frame_err),
      .proto_err(proto_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int last_valid_cyc = 0;
   int got_perr = 0;
   int got_ferr = 0;
   int exp_perr = 0;
   int exp_ferr = 0;
   logic [9:0] got_q[$];
   logic [9:0] exp_q[$];
   logic [7:0] stream[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rx_valid) begin
         got_q.push_back({rx_sop, rx_eop, rx_data});
         last_valid_cyc = cyc;
      end
      if (proto_err) got_perr++;
      if (frame_err) got_ferr++;
      if (frame_err || proto_err) begin
         checks++;
         assert (!(frame_err && proto_err)) else begin
            errors++;
            $error("FAIL err_overlap: observed both errors, expected at most one");
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      start_cyc = cyc;
      sbrx = 1'b0;
      repeat (OS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         sbrx = b[i];
         repeat (OS) @(negedge clk);
      end
      sbrx = stop_bit;
      repeat (OS) @(negedge clk);
      sbrx = 1'b1;
   endtask

   task automatic send_stream();
      while (stream.size() > 0) begin
         send_byte(stream.pop_front(), 1'b1);
      end
   endtask

   task automatic finish_compare(input string tag);
      repeat (40) @(negedge clk);
      check({tag, "_n"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) check({tag, "_ev"}, got_q[i], exp_q[i]);
      end
      check({tag, "_perr"}, got_perr, exp_perr);
      check({tag, "_ferr"}, got_ferr, exp_ferr);
      check({tag, "_busy"}, busy, 1'b0);
      got_q.delete();
      exp_q.delete();
      got_perr = 0;
      got_ferr = 0;
      exp_perr = 0;
      exp_ferr = 0;
   endtask

   // Build a stuffed transaction around a random payload and predict its outcome
   task automatic gen_txn(input int len);
      logic [7:0] pl[$];
      logic [7:0] b;
      stream.push_back(8'($urandom_range(0, 253)));
      stream.push_back(DLE);
      stream.push_back(STX);
      for (int i = 0; i < len; i++) begin
         if (i < MAXP && $urandom_range(0, 3) == 0) b = 8'hFE;
         else b = 8'($urandom_range(0, 253));
         pl.push_back(b);
         if (b == DLE) stream.push_back(DLE);
         stream.push_back(b);
      end
      stream.push_back(DLE);
      stream.push_back(ETX);
      if (len == 0) begin
         exp_perr++;
      end else if (len > MAXP) begin
         for (int i = 0; i < MAXP - 1; i++) exp_q.push_back({(i == 0), 1'b0, pl[i]});
         exp_perr++;
      end else begin
         for (int i = 0; i < len; i++) exp_q.push_back({(i == 0), (i == len - 1), pl[i]});
      end
   endtask

   initial begin
      logic saw_busy;
      sbrx = 1'b1;
      enable = 1'b1;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out", {rx_data, rx_valid, rx_sop, rx_eop, frame_err, proto_err, busy}, 14'h0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      stream = '{8'hFE, 8'h05, 8'h12, 8'h34, 8'hFE, 8'h40};
      exp_q = '{10'h212, 10'h134};
      send_stream();
      finish_compare("t1");
      check("t1_latency", last_valid_cyc - start_cyc, LAT);

      stream = '{8'hFE, 8'h05, 8'hFE, 8'hFE, 8'hFE, 8'h40};
      exp_q = '{10'h3FE};
      send_stream();
      finish_compare("t2");

      send_byte(8'h12, 1'b0);
      repeat (20) @(negedge clk);
      stream = '{8'hFE, 8'h05, 8'h12, 8'h34, 8'hFE, 8'h40};
      exp_q = '{10'h212, 10'h134};
      exp_ferr = 1;
      send_stream();
      finish_compare("t3");

      sbrx = 1'b0;
      repeat (4) @(negedge clk);
      sbrx = 1'b1;
      repeat (2) @(negedge clk);
      check("t4_start_busy", busy, 1'b1);
      finish_compare("t4");
`ifdef SB_RX_GLITCH_FILTER_EN
      saw_busy = 1'b0;
      sbrx = 1'b0;
      @(negedge clk);
      sbrx = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      check("t4_glitch_idle", saw_busy, 1'b0);
`endif

      stream = '{8'hFE, 8'h05, 8'hFE, 8'h40};
      exp_perr = 1;
      send_stream();
      finish_compare("t5a");
      stream = '{8'hFE, 8'h05, 8'h11, 8'hFE, 8'h07};
      exp_perr = 1;
      send_stream();
      finish_compare("t5b");

      stream = '{8'hFE, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      exp_q = '{10'h201, 10'h002, 10'h003};
      exp_perr = 1;
      send_stream();
      finish_compare("t6");

      stream = '{8'hFE, 8'h05, 8'h11};
      send_stream();
      repeat (5) @(negedge clk);
      check("en_open_busy", busy, 1'b1);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      check("en_off_busy", busy, 1'b0);
      repeat (10) @(negedge clk);
      enable = 1'b1;
      repeat (5) @(negedge clk);
      stream = '{8'hFE, 8'h40};
      send_stream();
      finish_compare("en");

      sbrx = 1'b0;
      repeat (OS) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         sbrx = 1'b1;
         repeat (OS) @(negedge clk);
      end
      check("rst_mid_busy", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_out", {rx_data, rx_valid, rx_sop, rx_eop, frame_err, proto_err, busy}, 14'h0);
      sbrx = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      stream = '{8'hFE, 8'h05, 8'hAB, 8'hFE, 8'h40};
      exp_q = '{10'h3AB};
      send_stream();
      finish_compare("rst_clean");

      for (int t = 0; t < 8; t++) begin
         gen_txn($urandom_range(0, 6));
         send_stream();
         finish_compare("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
